rgb_hue_sequencer: RTL
======================

# rgb_hue_sequencer

Controller that sequences three PWM channels through a continuous hue wheel and drives the board RGB LED pins directly. It owns a shared PWM period counter, one duty register per channel, and a six-state sector FSM that ramps exactly one channel per sector. It replaces free-running per-channel PWM logic in the top level; `top` instantiates it and wires its pins to the LED.

## Interface
- `PWM_INTERVAL`, default 1200: clock cycles per PWM period; also the full-scale duty value.
- `DUTY_STEP`, default 12: duty change applied to the ramping channel once per PWM period.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `hold` input 1: freezes the sequencer. Present only with `RGB_SEQ_HOLD_EN`.
- `RGB_R`, `RGB_G`, `RGB_B` output 1 each: LED drives, active-low, registered.
- `sector` output 3: current FSM state encoding, registered.
- `period_tick` output 1: one-cycle pulse marking the start of each PWM period.

## Operation
- **PWM counter** `pwm_cnt`:
  - Width `$clog2(PWM_INTERVAL)`; counts 0 to `PWM_INTERVAL-1`, then wraps to 0.
  - The edge at which it wraps is the "update edge".
- **Duty registers** `duty_r/g/b`:
  - Width `$clog2(PWM_INTERVAL+1)`; range 0..`PWM_INTERVAL`.
  - Change only at the update edge, so there are no mid-period glitches.
- **Channel output**: channel x is on when `pwm_cnt < duty_x`. The pin is registered as `RGB_x <= ~on_x`.
- **Sector FSM** (one channel ramps, the others hold):
  - 0 G_UP: R=full, G rises.
  - 1 R_DOWN: G=full, R falls.
  - 2 B_UP: B rises.
  - 3 G_DOWN: G falls.
  - 4 R_UP: R rises.
  - 5 B_DOWN: B falls.
  - After 5, returns to 0.
- **Ramp arithmetic**:
  - Up: `duty = min(duty + DUTY_STEP, PWM_INTERVAL)`.
  - Down: `duty = max(duty - DUTY_STEP, 0)`, computed without underflow.
- **Sector advance**: when the ramped value equals its target (`PWM_INTERVAL` for up, 0 for down), the FSM advances at that same update edge.
- **Illegal `sector` 6/7**: the next edge loads the reset state (sector 0, R=full, G=B=0).
- **Full hue cycle**: `6 × ceil(PWM_INTERVAL/DUTY_STEP)` PWM periods.
- **Parameter legality**: `DUTY_STEP` ≥ 1 and ≤ `PWM_INTERVAL`; `PWM_INTERVAL` ≥ 2. Elaboration error otherwise.

## Timing
- **Reset** (`rst_n` low at an edge):
  - `pwm_cnt`=0, `sector`=0, `duty_r`=`PWM_INTERVAL`, `duty_g`=`duty_b`=0.
  - `RGB_R`=`RGB_G`=`RGB_B`=1 (off), `period_tick`=0.
  - Takes effect at the next edge, regardless of counter or FSM position.
- **Output latency**: one cycle. The pin value in cycle n+1 reflects `pwm_cnt` and duty in cycle n.
- **First edge after reset release**: `pwm_cnt` 0 → `RGB_R`=0, `RGB_G`=`RGB_B`=1.
- **`period_tick`**: registered; high for exactly one cycle, in the cycle after the update edge. That is the same cycle in which the new duty and `sector` values are visible and `pwm_cnt`=0.
- **Duty 0**: channel never on. **Duty `PWM_INTERVAL`**: channel on every cycle of the period.
- **Ramp completion coincident with reset**: reset wins.

## Configuration
- **`RGB_SEQ_HOLD_EN` defined**:
  - Adds the `hold` port.
  - If `hold`=1 at an update edge, duties and `sector` keep their values.
  - `pwm_cnt`, `period_tick` and PWM outputs continue normally.
  - Ramping resumes at the first update edge with `hold`=0.
  - `hold` is ignored at all other edges.
- **Not defined**: no `hold` port; the sequencer advances at every update edge.

## Test plan
Bench uses `PWM_INTERVAL`=10 and `DUTY_STEP`=5 unless stated.
- **Reset**: `rst_n`=0 for 3 cycles → all RGB=1, `sector`=0, `period_tick`=0.
- **First period after release**: `RGB_R` low for 10/10 cycles, G and B high. Second period: `RGB_G` low for 5/10 cycles; `period_tick` pulses every 10 cycles.
- **Full cycle**: `sector` steps 0→1 after 2 periods, then 1→2→3→4→5→0. After 12 periods the LED duties are R=10, G=0, B=0 again (120 clocks).
- **Reset mid-operation**: `rst_n`=0 at `sector`=2 with `pwm_cnt`=4 → next edge matches the reset values exactly.
- **Clamping** (`DUTY_STEP`=4): G low-cycle counts per period are 0, 4, 8, 10, and `sector` advances on the period where G reaches 10.
- **`RGB_SEQ_HOLD_EN`**: `hold`=1 across 3 update edges in sector 1 → `sector` and low-cycle counts unchanged, `period_tick` still pulses. Release → ramp resumes at the next update edge.

Source files
------------

// File: rtl/rgb_hue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_hue_sequencer
// Brief    : Shared-counter PWM hue-wheel sequencer driving active-low RGB pins.
//            Optional macro RGB_SEQ_HOLD_EN adds a `hold` freeze input.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_hue_sequencer #(
    parameter int PWM_INTERVAL = 1200,
    parameter int DUTY_STEP    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef RGB_SEQ_HOLD_EN
    input  logic       hold,
`endif
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] sector,
    output logic       period_tick
);

    localparam int C_CNT_W  = $clog2(PWM_INTERVAL);
    localparam int C_DUTY_W = $clog2(PWM_INTERVAL + 1);

    localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(PWM_INTERVAL - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_DUTY_W-1:0] C_FULL     = C_DUTY_W'(PWM_INTERVAL);
    localparam logic [C_DUTY_W-1:0] C_STEP     = C_DUTY_W'(DUTY_STEP);

    generate
        if (PWM_INTERVAL < 2 || DUTY_STEP < 1 || DUTY_STEP > PWM_INTERVAL) begin : g_param_check
            $error("rgb_hue_sequencer: illegal PWM_INTERVAL/DUTY_STEP combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_G_UP   = 3'd0,
        S_R_DOWN = 3'd1,
        S_B_UP   = 3'd2,
        S_G_DOWN = 3'd3,
        S_R_UP   = 3'd4,
        S_B_DOWN = 3'd5
    } sector_e;

    sector_e               sector_q, sector_d;
    logic [C_CNT_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [C_DUTY_W-1:0]   duty_r_q, duty_r_d;
    logic [C_DUTY_W-1:0]   duty_g_q, duty_g_d;
    logic [C_DUTY_W-1:0]   duty_b_q, duty_b_d;
    logic                  rgb_r_q, rgb_r_d;
    logic                  rgb_g_q, rgb_g_d;
    logic                  rgb_b_q, rgb_b_d;
    logic                  period_tick_q, period_tick_d;

    logic                  w_update;
    logic                  w_advance;
    logic [C_DUTY_W-1:0]   w_cnt_ext;

    // Saturating ramps; the sum is one bit wider so it never wraps before the clamp.
    function automatic logic [C_DUTY_W-1:0] ramp_up(input logic [C_DUTY_W-1:0] d);
        logic [C_DUTY_W:0] sum;
        sum = {1'b0, d} + {1'b0, C_STEP};
        return (sum >= {1'b0, C_FULL}) ? C_FULL : sum[C_DUTY_W-1:0];
    endfunction

    function automatic logic [C_DUTY_W-1:0] ramp_down(input logic [C_DUTY_W-1:0] d);
        return (d <= C_STEP) ? '0 : (d - C_STEP);
    endfunction

    always_comb begin
        w_update  = (pwm_cnt_q == C_CNT_LAST);
`ifdef RGB_SEQ_HOLD_EN
        w_advance = w_update & ~hold;
`else
        w_advance = w_update;
`endif
        w_cnt_ext     = C_DUTY_W'(pwm_cnt_q);
        pwm_cnt_d     = w_update ? '0 : (pwm_cnt_q + C_CNT_ONE);
        period_tick_d = w_update;
        rgb_r_d       = ~(w_cnt_ext < duty_r_q);
        rgb_g_d       = ~(w_cnt_ext < duty_g_q);
        rgb_b_d       = ~(w_cnt_ext < duty_b_q);
    end

    always_comb begin
        sector_d = sector_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        case (sector_q)
            S_G_UP: if (w_advance) begin
                duty_g_d = ramp_up(duty_g_q);
                if (duty_g_d == C_FULL) sector_d = S_R_DOWN;
            end
            S_R_DOWN: if (w_advance) begin
                duty_r_d = ramp_down(duty_r_q);
                if (duty_r_d == '0) sector_d = S_B_UP;
            end
            S_B_UP: if (w_advance) begin
                duty_b_d = ramp_up(duty_b_q);
                if (duty_b_d == C_FULL) sector_d = S_G_DOWN;
            end
            S_G_DOWN: if (w_advance) begin
                duty_g_d = ramp_down(duty_g_q);
                if (duty_g_d == '0) sector_d = S_R_UP;
            end
            S_R_UP: if (w_advance) begin
                duty_r_d = ramp_up(duty_r_q);
                if (duty_r_d == C_FULL) sector_d = S_B_DOWN;
            end
            S_B_DOWN: if (w_advance) begin
                duty_b_d = ramp_down(duty_b_q);
                if (duty_b_d == '0) sector_d = S_G_UP;
            end
            // Unreachable encodings recover immediately, independent of the period.
            default: begin
                sector_d = S_G_UP;
                duty_r_d = C_FULL;
                duty_g_d = '0;
                duty_b_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q     <= '0;
            sector_q      <= S_G_UP;
            duty_r_q      <= C_FULL;
            duty_g_q      <= '0;
            duty_b_q      <= '0;
            rgb_r_q       <= 1'b1;
            rgb_g_q       <= 1'b1;
            rgb_b_q       <= 1'b1;
            period_tick_q <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            sector_q      <= sector_d;
            duty_r_q      <= duty_r_d;
            duty_g_q      <= duty_g_d;
            duty_b_q      <= duty_b_d;
            rgb_r_q       <= rgb_r_d;
            rgb_g_q       <= rgb_g_d;
            rgb_b_q       <= rgb_b_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign RGB_R       = rgb_r_q;
    assign RGB_G       = rgb_g_q;
    assign RGB_B       = rgb_b_q;
    assign sector      = sector_q;
    assign period_tick = period_tick_q;

endmodule
`default_nettype wire
